// File: rtl/twi_seq.sv
// twi_seq: sequences one I2C transfer (START/addr/wdata/RSTART/addr/rdata/RELEASE/STOP/OFF) onto twi_core's register port.
// Latency: all outputs registered; one register write per LOAD/ISSUE cycle, then a wait for i2cr[2] with a 2-cycle skip.
// Backpressure: req ignored while busy; each command waits on core done, bounded by TIMEOUT only with TWI_SEQ_TIMEOUT_EN.
`ifndef I2CR
`define I2CR 8'h01
`endif
`ifndef I2WD
`define I2WD 8'h02
`endif

module twi_seq #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] dev_addr,
    input  logic [3:0] wr_len,
    input  logic [3:0] rd_len,
    input  logic [7:0] wdata,
    output logic       wdata_rd,
    output logic [7:0] rdata,
    output logic       rdata_vld,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       twi_wr,
    output logic [7:0] twi_addr,
    output logic [7:0] twi_dout,
    input  logic [7:0] twi_i2cr,
    input  logic [7:0] twi_i2rd
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, WDATA, RSTART, ADDR_R, RDATA, RELEASE, STOP, OFF, FIN
    } state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_ISSUE, PH_WAIT} phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [1:0] skip_q, skip_d;
    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic [6:0] addr_q, addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rdata_vld_q, rdata_vld_d;
    logic       wdata_rd_q, wdata_rd_d;
    logic       twi_wr_q, twi_wr_d;
    logic [7:0] twi_addr_q, twi_addr_d;
    logic [7:0] twi_dout_q, twi_dout_d;
`ifdef TWI_SEQ_TIMEOUT_EN
    logic [11:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    logic unused_i2cr;
    assign unused_i2cr = ^{twi_i2cr[7:3], twi_i2cr[1:0]};

    function automatic logic [7:0] issue_byte(input state_t s);
        logic [2:0] cmd;
        case (s)
            ADDR_W, ADDR_R, WDATA: cmd = 3'b001;
            RDATA:                 cmd = 3'b010;
            STOP:                  cmd = 3'b011;
            RELEASE:               cmd = 3'b100;
            default:               cmd = 3'b000;
        endcase
        return {1'b0, cmd, 4'b0011};
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        skip_d      = skip_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
`ifdef TWI_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = dev_addr;
                    wr_cnt_d = wr_len;
                    rd_cnt_d = rd_len;
                    busy_d   = 1'b1;
                    state_d  = START;
                    phase_d  = PH_ISSUE;
`ifdef TWI_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
            end
            OFF:     state_d = FIN;
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            RELEASE: begin
                state_d = STOP;
                phase_d = PH_ISSUE;
            end
            default: begin
                case (phase_q)
                    PH_LOAD:  phase_d = PH_ISSUE;
                    PH_ISSUE: begin
                        phase_d = PH_WAIT;
                        skip_d  = 2'd2;
`ifdef TWI_SEQ_TIMEOUT_EN
                        tmo_d   = 12'd0;
`endif
                    end
                    default: begin
`ifdef TWI_SEQ_TIMEOUT_EN
                        tmo_d = tmo_q + 12'd1;
`endif
                        // the first two WAIT cycles cover twi_core's init/done clear latency
                        if (skip_q != 2'd0) begin
                            skip_d = skip_q - 2'd1;
                        end else if (twi_i2cr[2]) begin
                            case (state_q)
                                START: begin
                                    state_d = (wr_cnt_q == 4'd0 && rd_cnt_q != 4'd0) ? ADDR_R : ADDR_W;
                                    phase_d = PH_LOAD;
                                end
                                ADDR_W: begin
                                    state_d = (wr_cnt_q != 4'd0) ? WDATA : STOP;
                                    phase_d = (wr_cnt_q != 4'd0) ? PH_LOAD : PH_ISSUE;
                                end
                                WDATA: begin
                                    wr_cnt_d = wr_cnt_q - 4'd1;
                                    if (wr_cnt_q > 4'd1) begin
                                        phase_d = PH_LOAD;
                                    end else begin
                                        state_d = (rd_cnt_q != 4'd0) ? RSTART : STOP;
                                        phase_d = PH_ISSUE;
                                    end
                                end
                                RSTART: begin
                                    state_d = ADDR_R;
                                    phase_d = PH_LOAD;
                                end
                                ADDR_R: begin
                                    state_d = RDATA;
                                    phase_d = PH_ISSUE;
                                end
                                RDATA: begin
                                    rdata_d     = twi_i2rd;
                                    rdata_vld_d = 1'b1;
                                    rd_cnt_d    = rd_cnt_q - 4'd1;
                                    state_d     = (rd_cnt_q > 4'd1) ? RDATA : RELEASE;
                                    phase_d     = PH_ISSUE;
                                end
                                STOP:    state_d = OFF;
                                default: state_d = IDLE;
                            endcase
                        end
`ifdef TWI_SEQ_TIMEOUT_EN
                        if (tmo_d == 12'(TIMEOUT) && !(skip_q == 2'd0 && twi_i2cr[2])) begin
                            err_d   = 1'b1;
                            state_d = (state_q == STOP) ? OFF : STOP;
                            phase_d = PH_ISSUE;
                        end
`endif
                    end
                endcase
            end
        endcase

        // outputs are decoded from the next state so they register in step with it
        twi_wr_d   = 1'b0;
        twi_addr_d = 8'h00;
        twi_dout_d = 8'h00;
        wdata_rd_d = 1'b0;
        case (state_d)
            IDLE, FIN: begin
            end
            OFF: begin
                twi_wr_d   = 1'b1;
                twi_addr_d = `I2CR;
            end
            default: begin
                if (phase_d == PH_LOAD) begin
                    twi_wr_d   = 1'b1;
                    twi_addr_d = `I2WD;
                    twi_dout_d = (state_d == WDATA) ? wdata : {addr_d, state_d == ADDR_R};
                    wdata_rd_d = (state_d == WDATA);
                end else if (phase_d == PH_ISSUE) begin
                    twi_wr_d   = 1'b1;
                    twi_addr_d = `I2CR;
                    twi_dout_d = issue_byte(state_d);
                end
            end
        endcase
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= PH_LOAD;
            skip_q      <= 2'd0;
            wr_cnt_q    <= 4'd0;
            rd_cnt_q    <= 4'd0;
            addr_q      <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 8'h00;
            rdata_vld_q <= 1'b0;
            wdata_rd_q  <= 1'b0;
            twi_wr_q    <= 1'b0;
            twi_addr_q  <= 8'h00;
            twi_dout_q  <= 8'h00;
`ifdef TWI_SEQ_TIMEOUT_EN
            tmo_q       <= 12'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            skip_q      <= skip_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            wdata_rd_q  <= wdata_rd_d;
            twi_wr_q    <= twi_wr_d;
            twi_addr_q  <= twi_addr_d;
            twi_dout_q  <= twi_dout_d;
`ifdef TWI_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign wdata_rd  = wdata_rd_q;
    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign twi_wr    = twi_wr_q;
    assign twi_addr  = twi_addr_q;
    assign twi_dout  = twi_dout_q;
`ifdef TWI_SEQ_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_twi_seq.sv
// Bench for twi_seq: behavioural twi_core model plus expected register-write sequences built from the transfer rules.
// Latency: checks register traffic order and counts, not cycle positions; core done latency is randomised 1..6.
// Backpressure: the core model holds done low until its latency expires (or forever in the stall case).
`timescale 1ns/1ps
`ifndef I2CR
`define I2CR 8'h01
`endif
`ifndef I2WD
`define I2WD 8'h02
`endif

module tb_twi_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [3:0] wr_len = 4'd0;
    logic [3:0] rd_len = 4'd0;
    logic [7:0] wdata = 8'h00;
    logic       wdata_rd, rdata_vld, busy, done, err, twi_wr;
    logic [7:0] rdata, twi_addr, twi_dout;
    logic [7:0] twi_i2cr = 8'h00;
    logic [7:0] twi_i2rd = 8'h00;

    always #5 clk = ~clk;

    twi_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .dev_addr(dev_addr), .wr_len(wr_len), .rd_len(rd_len),
        .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy),
        .done(done), .err(err), .twi_wr(twi_wr), .twi_addr(twi_addr), .twi_dout(twi_dout),
        .twi_i2cr(twi_i2cr), .twi_i2rd(twi_i2rd));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] wq[$], rq[$], cr_log[$], wd_log[$], rd_log[$], exp_cr[$], exp_wd[$];
    logic [7:0] wbytes[16], rbytes[16];
    int  n_pop = 0, n_done = 0, lat = 0;
    bit  rd_pend = 0, stall_wd = 0;

    // twi_core stand-in: sees register writes, completes each command after a random latency
    always @(negedge clk) begin
        logic [7:0] tmp;
        if (rst) begin
            lat = 0;
            rd_pend = 0;
            twi_i2cr = 8'h00;
            twi_i2rd = 8'h00;
        end else begin
            if (twi_wr) begin
                if (twi_addr == `I2WD) wd_log.push_back(twi_dout);
                else if (twi_addr == `I2CR) begin
                    cr_log.push_back(twi_dout);
                    if (twi_dout != 8'h00) begin
                        twi_i2cr[2] = 1'b0;
                        rd_pend = (twi_dout[6:4] == 3'b010);
                        if (stall_wd && twi_dout[6:4] == 3'b001 && wd_log.size() >= 2) lat = 0;
                        else lat = $urandom_range(1, 6);
                    end
                end
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    twi_i2cr[2] = 1'b1;
                    if (rd_pend && rq.size() > 0) twi_i2rd = rq.pop_front();
                end
            end
            if (wdata_rd) begin
                n_pop++;
                if (wq.size() > 0) tmp = wq.pop_front();
            end
            wdata = (wq.size() > 0) ? wq[0] : 8'h00;
            if (rdata_vld) rd_log.push_back(rdata);
            if (done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // expected twi_core register traffic for one transfer, from the sequencing rules
    task automatic build_exp(input logic [6:0] a, input int wl, input int rl, input bit tmo);
        exp_cr.delete();
        exp_wd.delete();
        exp_cr.push_back(8'h03);
        if (wl > 0 || rl == 0) begin
            exp_cr.push_back(8'h13);
            exp_wd.push_back({a, 1'b0});
        end
        if (tmo) begin
            exp_cr.push_back(8'h13);
            exp_wd.push_back(wbytes[0]);
        end else begin
            for (int i = 0; i < wl; i++) begin
                exp_cr.push_back(8'h13);
                exp_wd.push_back(wbytes[i]);
            end
            if (rl > 0) begin
                if (wl > 0) exp_cr.push_back(8'h03);
                exp_cr.push_back(8'h13);
                exp_wd.push_back({a, 1'b1});
            end
            for (int i = 0; i < rl; i++) exp_cr.push_back(8'h23);
            if (rl > 0) exp_cr.push_back(8'h43);
        end
        exp_cr.push_back(8'h33);
        exp_cr.push_back(8'h00);
    endtask

    task automatic start_xfer(input logic [6:0] a, input int wl, input int rl);
        cr_log.delete(); wd_log.delete(); rd_log.delete(); wq.delete(); rq.delete();
        n_pop = 0;
        n_done = 0;
        for (int i = 0; i < wl; i++) wq.push_back(wbytes[i]);
        for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
        for (int i = 0; i < rl; i++) rq.push_back(rbytes[i]);
        dev_addr = a;
        wr_len = 4'(wl);
        rd_len = 4'(rl);
        req = 1'b1;
        step();
        req = 1'b0;
        dev_addr = 7'($urandom);
        wr_len = 4'($urandom);
        rd_len = 4'($urandom);
    endtask

    task automatic run_xfer(input string tag, input logic [6:0] a, input int wl, input int rl,
                            input bit extra_req, input bit tmo);
        int cyc = 0;
        int busy_bad = 0;
        int nc, nw, nr;
        start_xfer(a, wl, rl);
        build_exp(a, wl, rl, tmo);
        while (n_done == 0 && cyc < 4000) begin
            if (!busy) busy_bad++;
            if (extra_req && cyc == 20) begin
                dev_addr = 7'h11;
                wr_len = 4'd3;
                rd_len = 4'd3;
                req = 1'b1;
            end
            step();
            req = 1'b0;
            cyc++;
        end
        chk({tag, ".in_time"}, 32'(cyc < 4000), 32'd1);
        chk({tag, ".busy_held"}, 32'(busy_bad), 32'd0);
        chk({tag, ".busy_off"}, 32'(busy), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'(tmo));
        for (int i = 0; i < 6; i++) step();
        chk({tag, ".done_cnt"}, 32'(n_done), 32'd1);
        chk({tag, ".cr_len"}, 32'(cr_log.size()), 32'(exp_cr.size()));
        nc = (cr_log.size() < exp_cr.size()) ? cr_log.size() : exp_cr.size();
        for (int i = 0; i < nc; i++) chk({tag, ".cr"}, 32'(cr_log[i]), 32'(exp_cr[i]));
        chk({tag, ".wd_len"}, 32'(wd_log.size()), 32'(exp_wd.size()));
        nw = (wd_log.size() < exp_wd.size()) ? wd_log.size() : exp_wd.size();
        for (int i = 0; i < nw; i++) chk({tag, ".wd"}, 32'(wd_log[i]), 32'(exp_wd[i]));
        chk({tag, ".pops"}, 32'(n_pop), tmo ? 32'd1 : 32'(wl));
        chk({tag, ".rd_len"}, 32'(rd_log.size()), 32'(rl));
        nr = (rd_log.size() < rl) ? rd_log.size() : rl;
        for (int i = 0; i < nr; i++) chk({tag, ".rdata"}, 32'(rd_log[i]), 32'(rbytes[i]));
    endtask

    initial begin
        int cyc;
        int ncr;
        #1;
        chk("reset.outs", 32'({wdata_rd, rdata, rdata_vld, busy, done, err, twi_wr, twi_addr, twi_dout}), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // T1: two write bytes, no read
        wbytes[0] = 8'hAA; wbytes[1] = 8'h55;
        run_xfer("t1", 7'h50, 2, 0, 1'b0, 1'b0);

        // T2: write one byte then read two
        wbytes[0] = 8'h10; rbytes[0] = 8'h3C; rbytes[1] = 8'hC3;
        run_xfer("t2", 7'h50, 1, 2, 1'b0, 1'b0);

        // T3: address probe
        run_xfer("t3", 7'h2B, 0, 0, 1'b0, 1'b0);

        // read-only transfer goes straight to ADDR_R
        rbytes[0] = 8'h81; rbytes[1] = 8'h7E; rbytes[2] = 8'h00;
        run_xfer("rd_only", 7'h7F, 0, 3, 1'b0, 1'b0);

        // T4: req pulsed while busy must be ignored
        wbytes[0] = 8'h01; wbytes[1] = 8'h02; wbytes[2] = 8'h03; rbytes[0] = 8'h44;
        run_xfer("t4", 7'h33, 3, 1, 1'b1, 1'b0);

        // maximum lengths
        for (int i = 0; i < 16; i++) begin
            wbytes[i] = 8'($urandom);
            rbytes[i] = 8'($urandom);
        end
        run_xfer("max", 7'h01, 15, 15, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) begin
                wbytes[i] = 8'($urandom);
                rbytes[i] = 8'($urandom);
            end
            run_xfer("rand", 7'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b0, 1'b0);
        end

`ifdef TWI_SEQ_TIMEOUT_EN
        // T5: core never finishes the first data byte
        stall_wd = 1;
        wbytes[0] = 8'hAA; wbytes[1] = 8'h55;
        run_xfer("t5", 7'h50, 2, 0, 1'b0, 1'b1);
        stall_wd = 0;
        chk("t5.err_held", 32'(err), 32'd1);
`endif

        // T6: async reset in the middle of a RDATA wait
        rbytes[0] = 8'h99; rbytes[1] = 8'h66; rbytes[2] = 8'h12;
        start_xfer(7'h50, 0, 3);
        cyc = 0;
        while (!(cr_log.size() > 0 && cr_log[cr_log.size() - 1] == 8'h23) && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("t6.reached_rdata", 32'(cyc < 2000), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6.async_outs", 32'({wdata_rd, rdata, rdata_vld, busy, done, err, twi_wr, twi_addr, twi_dout}), 32'd0);
        ncr = cr_log.size();
        step();
        step();
        chk("t6.no_stop", 32'(cr_log.size()), 32'(ncr));
        rst = 1'b0;
        step();
        chk("t6.idle_busy", 32'(busy), 32'd0);
        wbytes[0] = 8'hAA; wbytes[1] = 8'h55;
        run_xfer("t6.t1", 7'h50, 2, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
